data_mem_ctrl: RTL and testbench
================================

# data_mem_ctrl

MEM-stage data-memory controller: the responder on the EX/MEM pipeline register's memory-request outputs. It decodes the registered load/store request, runs a multi-cycle handshake with word-wide data memory, performs byte-lane alignment, byte-enable generation and load sign/zero extension, and drives BUSY_WAIT back to every pipeline register to freeze the pipeline until the access completes.

## Interface
Parameters:
- ADDR_W, 32, width of the byte address from the ALU result.

Ports:
- CLK  in  1  pipeline clock; all state changes on posedge.
- RESET  in  1  asynchronous, active-high.
- MEM_READ  in  3  load op: 000 none, 001 LB, 010 LH, 011 LW, 100 LBU, 101 LHU; 110 and 111 are treated as none.
- MEM_WRITE  in  3  store op: 000 none, 001 SB, 010 SH, 011 SW; other codes are treated as none.
- ADDRESS  in  ADDR_W  byte address (EX/MEM ALU result).
- WRITE_DATA  in  32  store data (EX/MEM second operand).
- READ_DATA  out  32  extended load result, valid in DONE.
- BUSY_WAIT  out  1  stall request to all pipeline registers.
- MISALIGNED  out  1  combinational flag for the current request.
- MEM_ADDR  out  ADDR_W-2  word address to memory.
- MEM_RD, MEM_WR  out  1  memory strobes, registered.
- MEM_BYTE_EN  out  4  write lane enables; bit i selects byte i (little-endian).
- MEM_WRITEDATA  out  32  lane-replicated store data.
- MEM_READDATA  in  32  memory word.
- MEM_BUSYWAIT  in  1  memory busy; combinational response to MEM_RD or MEM_WR.

## Operation
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE:
  - Valid aligned request: BUSY_WAIT=1 combinationally in the same cycle; capture address, op and store data; next state READ or WRITE.
  - Read and write both non-none: read wins and the write is dropped.
- READ/WRITE:
  - MEM_RD or MEM_WR held at 1; BUSY_WAIT=1.
  - At an edge with MEM_BUSYWAIT=0: latch MEM_READDATA (reads only), drop the strobe, go to DONE.
- DONE:
  - BUSY_WAIT=0 and READ_DATA valid, so the pipeline advances at this edge.
  - The request still visible on the inputs is ignored, because it is the one just served.
  - Next state is IDLE.
- Misaligned request (LH/LHU/SH with ADDRESS[0]=1, or LW/SW with ADDRESS[1:0]≠0):
  - MISALIGNED=1; no memory transaction; BUSY_WAIT stays 0.
  - READ_DATA=0; FSM stays in IDLE.
- Store lanes:
  - SB: data byte replicated to all four lanes; MEM_BYTE_EN = one-hot on ADDRESS[1:0].
  - SH: data half replicated to both halves; MEM_BYTE_EN = 0011 or 1100.
  - SW: MEM_BYTE_EN = 1111.
  - MEM_BYTE_EN = 0 whenever MEM_WR=0.
- Load extraction:
  - Select the byte or half by ADDRESS[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- READ_DATA holds its last value outside DONE. Stores leave it unchanged.

## Timing
- Reset (asynchronous, any state including mid-access):
  - State IDLE; MEM_RD, MEM_WR, MEM_BYTE_EN, MEM_ADDR, MEM_WRITEDATA, READ_DATA all 0.
  - BUSY_WAIT and MISALIGNED are then 0 unless a request is present.
  - An in-flight memory access is abandoned; the strobe drops immediately.
- Memory latency L is the number of cycles MEM_BUSYWAIT stays high after the strobe rises. BUSY_WAIT is high for L+2 cycles: one IDLE cycle, then L+1 READ/WRITE cycles.
- Back-to-back accesses: after DONE, the next request is detected in IDLE, so there is one non-stalled cycle between accesses.
- MEM_BUSYWAIT low on the first strobe cycle (L=0) is legal: DONE follows after one READ/WRITE cycle.

## Structure
- Shared package mem_ops_pkg holds:
  - load/store op encodings;
  - FSM state enum;
  - byte-enable constants.
- Sub-module lsu_align: purely combinational store lane replication, byte-enable generation, load extraction/extension and misalignment detection.
- The FSM and registers stay in data_mem_ctrl.

## Test plan
- LW at 0x40, memory word 0x8765_4321, L=3 -> BUSY_WAIT high for exactly 5 cycles; READ_DATA=0x8765_4321 in DONE.
- LB at 0x43 and LBU at 0x43, word 0x80FF_0000 -> READ_DATA=0xFFFF_FF80 and 0x0000_0080 respectively.
- SH at 0x22 with WRITE_DATA 0x1234_ABCD -> MEM_WRITEDATA=0xABCD_ABCD, MEM_BYTE_EN=1100, MEM_ADDR=0x8, MEM_WR for L+1 cycles.
- LW at 0x41 -> MISALIGNED=1, BUSY_WAIT=0, no MEM_RD pulse, READ_DATA=0.
- RESET pulsed during the 2nd READ cycle of L=5 -> MEM_RD drops immediately, state IDLE; the re-presented request restarts a full access.
- MEM_READ=011 and MEM_WRITE=011 together -> read performed, no MEM_WR; then back-to-back SB shows exactly one non-stalled cycle between accesses.

Source files
------------

// File: rtl/mem_ops_pkg.sv
// Shared encodings for the MEM-stage data-memory controller: load/store
// op codes, controller FSM states and write byte-enable constants.
package mem_ops_pkg;

  // Load op codes carried on MEM_READ; 110 and 111 behave as no load.
  typedef enum logic [2:0] {
    LD_NONE = 3'b000,
    LD_LB   = 3'b001,
    LD_LH   = 3'b010,
    LD_LW   = 3'b011,
    LD_LBU  = 3'b100,
    LD_LHU  = 3'b101
  } load_op_e;

  // Store op codes carried on MEM_WRITE; anything above 011 is no store.
  typedef enum logic [2:0] {
    ST_NONE = 3'b000,
    ST_SB   = 3'b001,
    ST_SH   = 3'b010,
    ST_SW   = 3'b011
  } store_op_e;

  // Controller states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_READ  = 2'b01,
    S_WRITE = 2'b10,
    S_DONE  = 2'b11
  } state_e;

  // Write lane enables, bit i = byte i (little-endian).
  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_LO_HALF = 4'b0011;
  localparam logic [3:0] BE_HI_HALF = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  // True when the MEM_READ code names a real load.
  function automatic logic is_load(input logic [2:0] op);
    return (op == LD_LB) || (op == LD_LH) || (op == LD_LW) ||
           (op == LD_LBU) || (op == LD_LHU);
  endfunction

  // True when the MEM_WRITE code names a real store.
  function automatic logic is_store(input logic [2:0] op);
    return (op == ST_SB) || (op == ST_SH) || (op == ST_SW);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic for the data-memory controller.
// The request side (live pipeline inputs) yields misalignment, store lane
// replication and byte enables; the captured side (op and offset latched
// when the access started) yields the extracted, extended load result.
module lsu_align
  import mem_ops_pkg::*;
(
  input  logic [2:0]  req_ld_op,
  input  logic [2:0]  req_st_op,
  input  logic [1:0]  req_off,
  input  logic [31:0] store_data,
  input  logic [2:0]  cap_ld_op,
  input  logic [1:0]  cap_off,
  input  logic [31:0] mem_word,
  output logic        misaligned,
  output logic [31:0] store_lanes,
  output logic [3:0]  byte_en,
  output logic [31:0] load_result
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // A pending load wins over a store, so only its alignment matters then.
  always_comb begin
    misaligned = 1'b0;
    if (is_load(req_ld_op)) begin
      case (req_ld_op)
        LD_LH, LD_LHU: misaligned = req_off[0];
        LD_LW:         misaligned = |req_off;
        default:       misaligned = 1'b0;
      endcase
    end else begin
      case (req_st_op)
        ST_SH:   misaligned = req_off[0];
        ST_SW:   misaligned = |req_off;
        default: misaligned = 1'b0;
      endcase
    end
  end

  // Replicate store data across lanes so memory only needs the enables.
  always_comb begin
    store_lanes = store_data;
    byte_en     = BE_NONE;
    case (req_st_op)
      ST_SB: begin
        store_lanes = {4{store_data[7:0]}};
        byte_en     = BE_BYTE0 << req_off;
      end
      ST_SH: begin
        store_lanes = {2{store_data[15:0]}};
        byte_en     = req_off[1] ? BE_HI_HALF : BE_LO_HALF;
      end
      ST_SW: begin
        store_lanes = store_data;
        byte_en     = BE_WORD;
      end
      default: begin
        store_lanes = store_data;
        byte_en     = BE_NONE;
      end
    endcase
  end

  // Pick the addressed byte and half out of the returned memory word.
  always_comb begin
    case (cap_off)
      2'd0:    sel_byte = mem_word[7:0];
      2'd1:    sel_byte = mem_word[15:8];
      2'd2:    sel_byte = mem_word[23:16];
      default: sel_byte = mem_word[31:24];
    endcase
    sel_half = cap_off[1] ? mem_word[31:16] : mem_word[15:0];
  end

  // Sign- or zero-extend the selected field to the register width.
  always_comb begin
    case (cap_ld_op)
      LD_LB:   load_result = {{24{sel_byte[7]}}, sel_byte};
      LD_LBU:  load_result = {24'd0, sel_byte};
      LD_LH:   load_result = {{16{sel_half[15]}}, sel_half};
      LD_LHU:  load_result = {16'd0, sel_half};
      LD_LW:   load_result = mem_word;
      default: load_result = 32'd0;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage data-memory controller. Accepts the EX/MEM load/store request,
// runs a strobe/busy handshake with word-wide memory and stalls the whole
// pipeline through BUSY_WAIT until the access has finished.
module data_mem_ctrl
  import mem_ops_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [2:0]        MEM_READ,
  input  logic [2:0]        MEM_WRITE,
  input  logic [ADDR_W-1:0] ADDRESS,
  input  logic [31:0]       WRITE_DATA,
  output logic [31:0]       READ_DATA,
  output logic              BUSY_WAIT,
  output logic              MISALIGNED,
  output logic [ADDR_W-3:0] MEM_ADDR,
  output logic              MEM_RD,
  output logic              MEM_WR,
  output logic [3:0]        MEM_BYTE_EN,
  output logic [31:0]       MEM_WRITEDATA,
  input  logic [31:0]       MEM_READDATA,
  input  logic              MEM_BUSYWAIT
);

  state_e      state;
  state_e      state_next;
  logic        req_is_load;
  logic        req_is_store;
  logic        req_valid;
  logic        req_misaligned;
  logic        accept;
  logic        finish;
  logic [2:0]  cap_ld_op;
  logic [1:0]  cap_off;
  logic [31:0] store_lanes;
  logic [3:0]  store_be;
  logic [31:0] load_result;
  logic [31:0] read_data_q;

  assign req_is_load  = is_load(MEM_READ);
  assign req_is_store = is_store(MEM_WRITE);
  assign req_valid    = req_is_load | req_is_store;
  assign MISALIGNED   = req_misaligned;

  // A rejected misaligned request reads back as zero while it sits in IDLE.
  assign READ_DATA = ((state == S_IDLE) && req_misaligned) ? 32'd0 : read_data_q;

  lsu_align u_align (
    .req_ld_op   (MEM_READ),
    .req_st_op   (MEM_WRITE),
    .req_off     (ADDRESS[1:0]),
    .store_data  (WRITE_DATA),
    .cap_ld_op   (cap_ld_op),
    .cap_off     (cap_off),
    .mem_word    (MEM_READDATA),
    .misaligned  (req_misaligned),
    .store_lanes (store_lanes),
    .byte_en     (store_be),
    .load_result (load_result)
  );

  // Next state and stall: stall starts in the same IDLE cycle the request
  // appears, and DONE always releases the pipeline for one cycle.
  always_comb begin
    state_next = state;
    BUSY_WAIT  = 1'b0;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid && !req_misaligned) begin
          BUSY_WAIT  = 1'b1;
          accept     = 1'b1;
          state_next = req_is_load ? S_READ : S_WRITE;
        end
      end
      S_READ, S_WRITE: begin
        BUSY_WAIT = 1'b1;
        if (!MEM_BUSYWAIT) begin
          finish     = 1'b1;
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State register; reset abandons any access in flight.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Capture the request and raise the strobe on accept, drop it on finish.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      MEM_ADDR      <= '0;
      MEM_RD        <= 1'b0;
      MEM_WR        <= 1'b0;
      MEM_BYTE_EN   <= BE_NONE;
      MEM_WRITEDATA <= 32'd0;
      cap_ld_op     <= LD_NONE;
      cap_off       <= 2'd0;
    end else if (accept) begin
      MEM_ADDR  <= ADDRESS[ADDR_W-1:2];
      cap_ld_op <= MEM_READ;
      cap_off   <= ADDRESS[1:0];
      MEM_RD    <= req_is_load;
      MEM_WR    <= !req_is_load;
      if (!req_is_load) begin
        MEM_WRITEDATA <= store_lanes;
        MEM_BYTE_EN   <= store_be;
      end
    end else if (finish) begin
      MEM_RD      <= 1'b0;
      MEM_WR      <= 1'b0;
      MEM_BYTE_EN <= BE_NONE;
    end
  end

  // Latch the extended load result when memory stops stalling a read.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      read_data_q <= 32'd0;
    end else if (finish && (state == S_READ)) begin
      read_data_q <= load_result;
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: a behavioural word memory with
// programmable latency, directed scenarios, then randomized accesses
// checked against an arithmetic reference model of loads and stores.
module tb_data_mem_ctrl;

  logic        CLK;
  logic        RESET;
  logic [2:0]  MEM_READ;
  logic [2:0]  MEM_WRITE;
  logic [31:0] ADDRESS;
  logic [31:0] WRITE_DATA;
  logic [31:0] READ_DATA;
  logic        BUSY_WAIT;
  logic        MISALIGNED;
  logic [29:0] MEM_ADDR;
  logic        MEM_RD;
  logic        MEM_WR;
  logic [3:0]  MEM_BYTE_EN;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;

  int          tests_run = 0;
  int          tests_failed = 0;
  int          lat = 0;
  int          strobe_cycles = 0;
  logic [31:0] mem_words [0:255];
  logic [31:0] ref_mem [0:255];
  logic [31:0] last_read = 32'd0;
  logic        pl_en = 1'b0;
  logic [7:0]  pl_idx = 8'd0;
  logic [31:0] pl_val = 32'd0;

  data_mem_ctrl #(.ADDR_W(32)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .MEM_READ      (MEM_READ),
    .MEM_WRITE     (MEM_WRITE),
    .ADDRESS       (ADDRESS),
    .WRITE_DATA    (WRITE_DATA),
    .READ_DATA     (READ_DATA),
    .BUSY_WAIT     (BUSY_WAIT),
    .MISALIGNED    (MISALIGNED),
    .MEM_ADDR      (MEM_ADDR),
    .MEM_RD        (MEM_RD),
    .MEM_WR        (MEM_WR),
    .MEM_BYTE_EN   (MEM_BYTE_EN),
    .MEM_WRITEDATA (MEM_WRITEDATA),
    .MEM_READDATA  (MEM_READDATA),
    .MEM_BUSYWAIT  (MEM_BUSYWAIT)
  );

  // Free-running clock.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory stays busy for lat cycles after a strobe rises.
  assign MEM_BUSYWAIT = (MEM_RD || MEM_WR) && (strobe_cycles < lat);
  assign MEM_READDATA = mem_words[MEM_ADDR[7:0]];

  // Count how long the current strobe has been up.
  always @(posedge CLK) begin
    if (MEM_RD || MEM_WR) strobe_cycles <= strobe_cycles + 1;
    else strobe_cycles <= 0;
  end

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  // Behavioural memory: preload port plus byte-enabled writes on completion.
  initial begin
    for (int i = 0; i < 256; i++) mem_words[i] = init_word(i);
    forever begin
      @(posedge CLK);
      if (pl_en) begin
        mem_words[pl_idx] <= pl_val;
      end else if (MEM_WR && !MEM_BUSYWAIT) begin
        for (int b = 0; b < 4; b++)
          if (MEM_BYTE_EN[b]) mem_words[MEM_ADDR[7:0]][8*b +: 8] <= MEM_WRITEDATA[8*b +: 8];
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Reference load: shift the addressed field down, mask, extend.
  function automatic logic [31:0] ref_load(input logic [2:0] op, input int off, input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> (8 * off);
    case (op)
      3'd1: return sh[7]  ? ((sh & 32'hFF)   | 32'hFFFF_FF00) : (sh & 32'hFF);
      3'd2: return sh[15] ? ((sh & 32'hFFFF) | 32'hFFFF_0000) : (sh & 32'hFFFF);
      3'd3: return word;
      3'd4: return sh & 32'hFF;
      3'd5: return sh & 32'hFFFF;
      default: return 32'd0;
    endcase
  endfunction

  // Clear the request (allowed in DONE) and write one word into both memories.
  task automatic preload(input int idx, input logic [31:0] val);
    MEM_READ  = 3'd0;
    MEM_WRITE = 3'd0;
    pl_idx = 8'(idx);
    pl_val = val;
    pl_en  = 1'b1;
    ref_mem[idx] = val;
    @(posedge CLK);
    #1;
    pl_en = 1'b0;
  endtask

  // Present one request right after a clock edge and follow it to the end.
  task automatic applyStimulus(input logic [2:0] ld, input logic [2:0] st,
                               input logic [31:0] addr, input logic [31:0] wd, input int l);
    bit          is_ld, is_st, mis, done_seen;
    int          size, off, widx, busy_n, rd_n, wr_n;
    logic [31:0] exp_lanes, mask, exp_rd;
    logic [3:0]  exp_be;
    is_ld = (ld >= 3'd1) && (ld <= 3'd5);
    is_st = !is_ld && (st >= 3'd1) && (st <= 3'd3);
    off   = int'(addr[1:0]);
    widx  = int'(addr[9:2]);
    size  = 0;
    if (is_ld) size = (ld == 3'd1 || ld == 3'd4) ? 1 : (ld == 3'd2 || ld == 3'd5) ? 2 : 4;
    else if (is_st) size = (st == 3'd1) ? 1 : (st == 3'd2) ? 2 : 4;
    mis = (size != 0) && ((off % size) != 0);

    @(posedge CLK);
    #1;
    lat = l;
    MEM_READ = ld; MEM_WRITE = st; ADDRESS = addr; WRITE_DATA = wd;
    @(negedge CLK);
    checkOutput("misaligned", 32'(MISALIGNED), 32'(mis));

    if (size == 0 || mis) begin
      for (int c = 0; c < 3; c++) begin
        checkOutput("no_stall", 32'(BUSY_WAIT), 32'd0);
        checkOutput("no_strobe", 32'({MEM_RD, MEM_WR}), 32'd0);
        if (mis) checkOutput("mis_rdata", READ_DATA, 32'd0);
        else checkOutput("hold_rdata", READ_DATA, last_read);
        @(negedge CLK);
      end
      return;
    end

    exp_lanes = (size == 1) ? wd[7:0] * 32'h0101_0101 :
                (size == 2) ? wd[15:0] * 32'h0001_0001 : wd;
    exp_be    = 4'(((1 << size) - 1) << off);
    busy_n = 0; rd_n = 0; wr_n = 0; done_seen = 0;
    for (int c = 0; c < 64 && !done_seen; c++) begin
      if (BUSY_WAIT) begin
        busy_n++;
        if (MEM_RD) begin
          if (rd_n == 0) checkOutput("rd_addr", 32'(MEM_ADDR), addr >> 2);
          rd_n++;
        end
        if (MEM_WR) begin
          if (wr_n == 0) begin
            checkOutput("wr_addr", 32'(MEM_ADDR), addr >> 2);
            checkOutput("wr_data", MEM_WRITEDATA, exp_lanes);
            checkOutput("wr_be", 32'(MEM_BYTE_EN), 32'(exp_be));
          end
          wr_n++;
        end
        @(negedge CLK);
      end else begin
        done_seen = 1;
      end
    end
    checkOutput("done_reached", 32'(done_seen), 32'd1);
    checkOutput("stall_len", 32'(busy_n), 32'(l + 2));
    checkOutput(is_ld ? "rd_len" : "wr_len", 32'(is_ld ? rd_n : wr_n), 32'(l + 1));
    checkOutput(is_ld ? "no_wr" : "no_rd", 32'(is_ld ? wr_n : rd_n), 32'd0);
    checkOutput("done_strobes", 32'({MEM_RD, MEM_WR, MEM_BYTE_EN}), 32'd0);
    if (is_ld) begin
      exp_rd = ref_load(ld, off, ref_mem[widx]);
      last_read = exp_rd;
      checkOutput("load_data", READ_DATA, exp_rd);
    end else begin
      mask = (size == 4) ? 32'hFFFF_FFFF : (((32'd1 << (8 * size)) - 32'd1) << (8 * off));
      ref_mem[widx] = (ref_mem[widx] & ~mask) | ((wd << (8 * off)) & mask);
      checkOutput("store_rdata", READ_DATA, last_read);
    end
  endtask

  // Directed scenarios first, then randomized traffic.
  initial begin
    logic [2:0]  r_ld, r_st;
    logic [31:0] r_addr;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    RESET = 1'b1;
    MEM_READ = 3'd0; MEM_WRITE = 3'd0; ADDRESS = 32'd0; WRITE_DATA = 32'd0;

    @(negedge CLK);
    checkOutput("rst_strobes", 32'({MEM_RD, MEM_WR, MEM_BYTE_EN}), 32'd0);
    checkOutput("rst_addr", 32'(MEM_ADDR), 32'd0);
    checkOutput("rst_wdata", MEM_WRITEDATA, 32'd0);
    checkOutput("rst_rdata", READ_DATA, 32'd0);
    checkOutput("rst_flags", 32'({BUSY_WAIT, MISALIGNED}), 32'd0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;

    preload(16, 32'h8765_4321);
    applyStimulus(3'd3, 3'd0, 32'h40, 32'd0, 3);
    preload(16, 32'h80FF_0000);
    applyStimulus(3'd1, 3'd0, 32'h43, 32'd0, 2);
    applyStimulus(3'd4, 3'd0, 32'h43, 32'd0, 0);
    applyStimulus(3'd0, 3'd2, 32'h22, 32'h1234_ABCD, 2);
    applyStimulus(3'd3, 3'd0, 32'h41, 32'd0, 1);

    preload(32, 32'hCAFE_F00D);
    @(posedge CLK);
    #1;
    lat = 5; MEM_READ = 3'd3; MEM_WRITE = 3'd0; ADDRESS = 32'h80;
    @(negedge CLK);
    @(negedge CLK);
    @(negedge CLK);
    checkOutput("pre_reset_rd", 32'(MEM_RD), 32'd1);
    RESET = 1'b1;
    MEM_READ = 3'd0;
    #1;
    checkOutput("reset_rd_drop", 32'(MEM_RD), 32'd0);
    checkOutput("reset_idle", 32'(BUSY_WAIT), 32'd0);
    checkOutput("reset_addr", 32'(MEM_ADDR), 32'd0);
    checkOutput("reset_rdata", READ_DATA, 32'd0);
    last_read = 32'd0;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    applyStimulus(3'd3, 3'd0, 32'h80, 32'd0, 5);

    applyStimulus(3'd3, 3'd3, 32'h84, 32'h1111_2222, 1);
    applyStimulus(3'd0, 3'd1, 32'h85, 32'h0000_00A5, 0);
    applyStimulus(3'd2, 3'd0, 32'h84, 32'd0, 1);

    for (int n = 0; n < 80; n++) begin
      r_ld   = 3'($urandom_range(0, 7));
      r_st   = 3'($urandom_range(0, 7));
      r_addr = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 2) != 0) r_addr = r_addr & ~32'd1;
      if ($urandom_range(0, 2) == 0) r_addr = r_addr & ~32'd3;
      if ($urandom_range(0, 1) == 0) r_ld = 3'd0;
      applyStimulus(r_ld, r_st, r_addr, $urandom, int'($urandom_range(0, 4)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
